// File: rtl/wcs_controlstore_if.sv
// Microcode load port between the loader (master) and the writable control store (slave).
// The loader streams beats with valid/ready and brackets the load with start/done pulses.
interface wcs_controlstore_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 25
);
  logic              load_start;
  logic              load_valid;
  logic              load_ready;
  logic [ADDR_W-1:0] load_addr;
  logic [WORD_W-1:0] load_data;
  logic              load_done;

  modport master (
    output load_start, load_valid, load_addr, load_data, load_done,
    input  load_ready
  );

  modport slave (
    input  load_start, load_valid, load_addr, load_data, load_done,
    output load_ready
  );
endinterface

// File: rtl/wcs_controlstore.sv
// Writable microprogram control store: RAM loaded at run time, registered control word
// one cycle after the state-ID address, with stall and unprogrammed/out-of-range fault flags.
module wcs_controlstore #(
  parameter int              ADDR_W     = 5,
  parameter int              WORD_W     = 25,
  parameter int              DEPTH      = 32,
  parameter logic [WORD_W-1:0] RESET_WORD = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              hold,
  wcs_controlstore_if.slave ld,
  output logic [WORD_W-1:0] controlword,
  output logic              cw_valid,
  output logic              fault,
  output logic              fault_sticky,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {EMPTY = 2'b00, LOAD = 2'b01, RUN = 2'b10} st_e;

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  st_e               st_q, st_d;
  logic [WORD_W-1:0] ram [DEPTH];
  logic [DEPTH-1:0]  ent_vld;

  logic             beat, ld_in, rd_in, rd_hit, start_eff, fetch;
  logic [IDX_W-1:0] ld_idx, rd_idx;

  assign ld_idx = ld.load_addr[IDX_W-1:0];
  assign rd_idx = address[IDX_W-1:0];
  assign ld_in  = ({1'b0, ld.load_addr} < DEPTH_L);
  assign rd_in  = ({1'b0, address} < DEPTH_L);
  // the index is only meaningful once the range check passes
  assign rd_hit = rd_in && ent_vld[rd_idx];

  assign ld.load_ready = (st_q == LOAD);
  assign beat          = ld.load_valid && ld.load_ready;
  // load_start is ignored while already loading
  assign start_eff     = ld.load_start && (st_q != LOAD);
  assign fetch         = (st_q == RUN) && !start_eff && !hold;
  assign state         = st_q;

  always_comb begin
    st_d = st_q;
    case (st_q)
      EMPTY:   if (ld.load_start) st_d = LOAD;
      LOAD:    if (ld.load_done)  st_d = RUN;
      RUN:     if (ld.load_start) st_d = LOAD;
      default: st_d = EMPTY;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) st_q <= EMPTY;
    else          st_q <= st_d;
  end

  // RAM contents survive reset; only the per-entry valid bits are cleared
  always_ff @(posedge clock) begin
    if (beat && ld_in) ram[ld_idx] <= ld.load_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)            ent_vld         <= '0;
    else if (beat && ld_in)  ent_vld[ld_idx] <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)               fault_sticky <= 1'b0;
    else if (start_eff)         fault_sticky <= 1'b0;
    else if (beat && !ld_in)    fault_sticky <= 1'b1;
    else if (fetch && !rd_hit)  fault_sticky <= 1'b1;
  end

  // Outside a live RUN cycle the word is forced to NOP, so the first RUN
  // cycle after load_done and the first LOAD cycle both show RESET_WORD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      controlword <= RESET_WORD;
      cw_valid    <= 1'b0;
      fault       <= 1'b0;
    end else if (st_q != RUN || start_eff) begin
      controlword <= RESET_WORD;
      cw_valid    <= 1'b0;
      fault       <= 1'b0;
    end else if (!hold) begin
      if (rd_hit) begin
        controlword <= ram[rd_idx];
        cw_valid    <= 1'b1;
        fault       <= 1'b0;
      end else begin
        controlword <= RESET_WORD;
        cw_valid    <= 1'b0;
        fault       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wcs_controlstore.sv
// Bench for wcs_controlstore (DEPTH=24): reference model feeds a scoreboard queue on each
// fetch/hold cycle; entries are popped and compared after the producing clock edge.
module tb_wcs_controlstore;
  localparam int AW = 5;
  localparam int WW = 25;
  localparam int DP = 24;

  logic          clock = 1'b0;
  logic          reset_n;
  logic [AW-1:0] address;
  logic          hold;
  logic [WW-1:0] controlword;
  logic          cw_valid, fault, fault_sticky;
  logic [1:0]    state;

  wcs_controlstore_if #(.ADDR_W(AW), .WORD_W(WW)) ld ();

  wcs_controlstore #(.ADDR_W(AW), .WORD_W(WW), .DEPTH(DP)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .hold(hold), .ld(ld),
    .controlword(controlword), .cw_valid(cw_valid), .fault(fault),
    .fault_sticky(fault_sticky), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WW-1:0] cw;
    logic          cv;
    logic          ft;
    logic          sk;
  } exp_t;

  exp_t sbq[$];
  int   vecs = 0;
  int   errs = 0;

  // reference model
  logic [WW-1:0] m_ram [32];
  logic          m_vld [32];
  logic          m_sk;
  exp_t          m_last;

  localparam logic [WW-1:0] W0  = 25'b011_00_000_000_001_010_0_00_10111;
  localparam logic [WW-1:0] W23 = 25'b101_11_000_000_000_000_1_01_00000;
  localparam logic [WW-1:0] W5  = 25'h1a5_5c3;
  localparam logic [WW-1:0] WZ  = 25'h0ff_0f0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_vld[i] = 1'b0;
    m_sk   = 1'b0;
    m_last = '{cw: '0, cv: 1'b0, ft: 1'b0, sk: 1'b0};
  endtask

  task automatic pulse_start();
    ld.load_start = 1'b1;
    tick();
    ld.load_start = 1'b0;
    m_sk   = 1'b0;
    m_last = '{cw: '0, cv: 1'b0, ft: 1'b0, sk: 1'b0};
    chk("st_load", 32'(state), 32'd1);
    chk("ld_rdy", 32'(ld.load_ready), 32'd1);
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [WW-1:0] d, input logic done);
    ld.load_valid = 1'b1;
    ld.load_addr  = a;
    ld.load_data  = d;
    ld.load_done  = done;
    tick();
    ld.load_valid = 1'b0;
    ld.load_done  = 1'b0;
    if (a < DP) begin
      m_ram[a] = d;
      m_vld[a] = 1'b1;
    end else begin
      m_sk = 1'b1;
    end
    chk("ld_cw0", 32'(controlword), 32'd0);
    chk("ld_sticky", 32'(fault_sticky), 32'(m_sk));
  endtask

  task automatic pulse_done();
    ld.load_done = 1'b1;
    tick();
    ld.load_done = 1'b0;
    chk("st_run", 32'(state), 32'd2);
    chk("run_cv0", 32'(cw_valid), 32'd0);
    chk("run_rdy", 32'(ld.load_ready), 32'd0);
  endtask

  // one RUN cycle: fetch (h=0) or stall (h=1)
  task automatic step(input logic [AW-1:0] a, input logic h);
    exp_t e;
    address = a;
    hold    = h;
    if (h) begin
      e = m_last;
    end else if (a < DP && m_vld[a]) begin
      e = '{cw: m_ram[a], cv: 1'b1, ft: 1'b0, sk: 1'b0};
    end else begin
      e = '{cw: '0, cv: 1'b0, ft: 1'b1, sk: 1'b0};
      m_sk = 1'b1;
    end
    e.sk   = m_sk;
    m_last = e;
    sbq.push_back(e);
    tick();
    hold = 1'b0;
    if (sbq.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("cw@%0d", a), 32'(controlword), 32'(e.cw));
      chk($sformatf("cv@%0d", a), 32'(cw_valid), 32'(e.cv));
      chk($sformatf("ft@%0d", a), 32'(fault), 32'(e.ft));
      chk($sformatf("sk@%0d", a), 32'(fault_sticky), 32'(e.sk));
    end
  endtask

  initial begin
    reset_n       = 1'b1;
    address       = '0;
    hold          = 1'b0;
    ld.load_start = 1'b0;
    ld.load_valid = 1'b0;
    ld.load_addr  = '0;
    ld.load_data  = '0;
    ld.load_done  = 1'b0;
    model_reset();

    // 1: reset, then run with nothing programmed
    #2 reset_n = 1'b0;
    #3;
    chk("rst_cw", 32'(controlword), 32'd0);
    chk("rst_cv", 32'(cw_valid), 32'd0);
    chk("rst_ft", 32'(fault), 32'd0);
    chk("rst_sk", 32'(fault_sticky), 32'd0);
    chk("rst_st", 32'(state), 32'd0);
    chk("rst_rdy", 32'(ld.load_ready), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("empty_st", 32'(state), 32'd0);
    pulse_start();
    pulse_done();
    step(5'd0, 1'b0);

    // 2 + 4: load two entries and one out-of-range beat, then fetch
    pulse_start();
    chk("sk_clr", 32'(fault_sticky), 32'd0);
    beat(5'd0, W0, 1'b0);
    beat(5'd23, W23, 1'b0);
    beat(5'd30, WZ, 1'b0);
    pulse_done();
    step(5'd0, 1'b0);
    step(5'd23, 1'b0);
    step(5'd30, 1'b0);

    // 3: hold keeps entry 0 while address points at 23
    pulse_start();
    pulse_done();
    step(5'd0, 1'b0);
    for (int i = 0; i < 3; i++) step(5'd23, 1'b1);
    step(5'd23, 1'b0);

    // 5: beat together with load_done is committed (partial reload)
    pulse_start();
    beat(5'd5, W5, 1'b1);
    chk("st_run5", 32'(state), 32'd2);
    step(5'd5, 1'b0);
    step(5'd0, 1'b0);

    // mixed fetch/stall traffic over valid, unwritten and out-of-range entries
    for (int i = 0; i < 24; i++)
      step(AW'($urandom_range(0, 31)), ($urandom_range(0, 3) == 0));

    // 6: async reset between edges, reload entry 0 only
    step(5'd23, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    chk("arst_cw", 32'(controlword), 32'd0);
    chk("arst_cv", 32'(cw_valid), 32'd0);
    chk("arst_st", 32'(state), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    tick();
    pulse_start();
    beat(5'd0, W5, 1'b0);
    pulse_done();
    step(5'd0, 1'b0);
    step(5'd23, 1'b0);
    step(5'd5, 1'b0);

    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
